gnrc_fifo_wr_arb: RTL and testbench
===================================

# gnrc_fifo_wr_arb

Round-robin write-side arbiter that shares one synchronous FIFO (`gnrc_fifo`, any `FWFT`/`BYPASS` setting) between `N` independent valid/ready producers. It selects one requester per cycle, muxes its data onto the FIFO push port, and back-pressures the rest. An optional packet lock holds the grant until the owner's `last` beat, so multi-beat packets land contiguously in the FIFO. It sits directly in front of the FIFO's `data_i`/`wen_i`/`full_o`; the read side is untouched.

## Interface
- `N`, 4: number of requesters, range ≥2.
- `DW`, 32: data width, must equal the FIFO's `DW`.
- `LOCK`, 1: 1 holds grant from first beat to `last` beat; 0 re-arbitrates every beat.
- `IW`, `$clog2(N)`: index width (derived, do not override).

- `clk_i` in 1: clock, positive edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `flush_i` in 1: same signal that drives FIFO `flush_i`; aborts arbitration state.
- `req_valid_i` in N: per-requester beat valid.
- `req_data_i` in N×DW: per-requester data, packed `[N-1:0][DW-1:0]`.
- `req_last_i` in N: final beat of packet (ignored when `LOCK`=0).
- `req_ready_o` out N: beat accepted when `valid & ready`.
- `fifo_wen_o` out 1: to FIFO `wen_i`.
- `fifo_data_o` out DW: to FIFO `data_i`.
- `fifo_full_i` in 1: from FIFO `full_o`.
- `gnt_o` out N: one-hot current grant (all-zero when no valid requester).
- `gnt_idx_o` out IW: binary index of `gnt_o`; holds last value when idle.
- `locked_o` out 1: high while in LOCKED state.

## Operation
- State machine, two states:
  - IDLE: winner is the first `req_valid_i` bit scanning upward from `ptr+1` modulo N.
  - LOCKED: winner is fixed to `owner` regardless of other valids.
- Transfer condition: `xfer = |gnt_o & req_valid_i[gnt_idx] & ~fifo_full_i & ~flush_i`.
  - `req_ready_o[gnt_idx] = ~fifo_full_i & ~flush_i`; every other ready bit is 0.
  - `fifo_wen_o = xfer`; `fifo_data_o = req_data_i[gnt_idx]` (0 when `gnt_o` is 0).
- Transitions:
  - IDLE → LOCKED when `LOCK`=1, `xfer`, and `~req_last_i[winner]`; `owner <= winner`.
  - LOCKED → IDLE on `xfer & req_last_i[owner]`.
  - A single-beat packet (`last` on first beat) stays in IDLE.
- Pointer update: `ptr <= gnt_idx` on every `xfer` in IDLE, and on the final `xfer` in LOCKED. It never updates without a transfer, so a requester blocked by full keeps its priority.
- In LOCKED with owner `valid`=0, the grant is held; no other requester is served (bubbles allowed).
- `flush_i` or `rst_i`: state ← IDLE, `ptr` ← N-1 (requester 0 highest next), `owner` ← 0, stats cleared. A packet in flight is dropped mid-stream; the producer must restart it.
- Grant is never given to a requester with `valid`=0 in IDLE, so no beat is lost to a misdirected ready.

## Timing
- Zero-cycle latency: `req_valid_i` → `fifo_wen_o`/`req_ready_o` is combinational. The only registers are `state`, `ptr`, `owner`, and the optional counters.
- `req_ready_o` depends on `fifo_full_i`, so the FIFO must not use `BYPASS` in a loop back to its producers.
- Throughput: one beat per cycle while not full. Back-to-back grants to different requesters have no dead cycle.
- Values after reset: `req_ready_o`=0 until a valid appears, `fifo_wen_o`=0, `gnt_o`=0, `gnt_idx_o`=0, `locked_o`=0.
- Full: no transfer and no state or pointer change. The same winner is re-evaluated next cycle.
- Simultaneous `flush_i` and `xfer` candidate: flush wins, nothing is written.

## Configuration
- `GNRC_FIFO_ARB_STATS_EN` defined:
  - Adds output `stat_cnt_o` [N×16], one per-requester saturating count of accepted beats, stopping at 16'hFFFF.
  - Cleared by reset or flush.
- `GNRC_FIFO_ARB_STATS_EN` undefined: port and counters are absent; behaviour is otherwise identical.

## Structure
- Shared package `gnrc_arb_pkg` holds:
  - enum `arb_state_e {ARB_IDLE, ARB_LOCKED}`;
  - localparam `STAT_W = 16`.
- Sub-module `gnrc_rr_pick`: purely combinational rotate-priority picker (`req`[N], `ptr`[IW] → `gnt`[N], `idx`[IW], `any`). It is reused by the read-side scheduler later.

## Test plan
- Reset, then all four valids high with `LOCK`=0 and FIFO never full → grants 0,1,2,3,0 on consecutive cycles, one `fifo_wen_o` per cycle, data equals the granted requester's word.
- `LOCK`=1, req1 sends a 3-beat packet (last on beat 3) while req0, req2, and req3 hold valid → beats 1,1,1 land contiguously, `locked_o` is high for 2 cycles, next grant is 2.
- `fifo_full_i` asserted for 5 cycles with req2 granted → `fifo_wen_o`=0 and all ready=0 for 5 cycles, `ptr` unchanged, req2 is served in the cycle full drops.
- `flush_i` pulse mid-packet (owner 3, beat 2 of 4) → no write that cycle, `locked_o`=0 next cycle, next grant goes to the lowest valid index from 0.
- Only req3 valid, locked, deasserts valid for 2 cycles while req0 is valid → no grant to req0, no writes, and the lock resumes with req3's next beat.
- With `GNRC_FIFO_ARB_STATS_EN`, drive 70000 beats on req0 → `stat_cnt_o[0]` = 16'hFFFF, other counters are 0.

Source files
------------

// File: rtl/gnrc_arb_pkg.sv
// gnrc_arb_pkg
//   Shared types and constants for the generic FIFO arbiters.
//   - arb_state_e : arbiter FSM state (IDLE re-arbitrates, LOCKED holds owner)
//   - STAT_W      : width of each per-requester accepted-beat counter
package gnrc_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  localparam int STAT_W = 16;

endpackage

// File: rtl/gnrc_rr_pick.sv
// gnrc_rr_pick
//   Purely combinational rotate-priority picker. Scans req upward starting at
//   ptr+1 (modulo N) and grants the first set bit.
// Ports:
//   req [N]  : request vector
//   ptr [IW] : index of the most recently served requester (lowest priority)
//   gnt [N]  : one-hot grant, all-zero when no request
//   idx [IW] : binary index of gnt (0 when no request)
//   any      : at least one request present
module gnrc_rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    logic [IW-1:0] j;
    // NOTE: every variable written here gets a default first, otherwise
    // paths that skip an assignment infer a latch.
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = '0;
    // Offset 1 first, offset N last: ptr itself is the lowest priority.
    for (int k = 1; k <= N; k++) begin
      j = IW'((int'(ptr) + k) % N);
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/gnrc_fifo_wr_arb.sv
// gnrc_fifo_wr_arb
//   Round-robin write-side arbiter sharing one synchronous FIFO among N
//   valid/ready producers. Optional packet lock keeps the grant on one owner
//   from its first beat to its last beat so packets land contiguously.
//   Build option: define GNRC_FIFO_ARB_STATS_EN to add per-requester
//   saturating accepted-beat counters on stat_cnt_o.
// Ports:
//   clk_i, rst_i (sync, active-high), flush_i (shared with FIFO flush)
//   req_valid_i/req_data_i/req_last_i/req_ready_o : N producer channels
//   fifo_wen_o/fifo_data_o/fifo_full_i            : FIFO push port
//   gnt_o/gnt_idx_o/locked_o                      : grant observability
//   stat_cnt_o (GNRC_FIFO_ARB_STATS_EN only)      : N x STAT_W beat counts
module gnrc_fifo_wr_arb
  import gnrc_arb_pkg::*;
#(
  parameter int N    = 4,
  parameter int DW   = 32,
  parameter bit LOCK = 1'b1,
  parameter int IW   = $clog2(N)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic [N-1:0]          req_valid_i,
  input  logic [N-1:0][DW-1:0]  req_data_i,
  input  logic [N-1:0]          req_last_i,
  output logic [N-1:0]          req_ready_o,
  output logic                  fifo_wen_o,
  output logic [DW-1:0]         fifo_data_o,
  input  logic                  fifo_full_i,
  output logic [N-1:0]          gnt_o,
  output logic [IW-1:0]         gnt_idx_o,
  output logic                  locked_o
`ifdef GNRC_FIFO_ARB_STATS_EN
  ,
  output logic [N-1:0][STAT_W-1:0] stat_cnt_o
`endif
);

  arb_state_e    state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] owner;
  logic [IW-1:0] idx_hold;  // last granted index, shown while idle

  logic [N-1:0]  pick_gnt;
  logic [IW-1:0] pick_idx;
  logic          pick_any;

  logic          any_gnt;
  logic [IW-1:0] sel_idx;
  logic          open;
  logic          xfer;

  gnrc_rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req (req_valid_i),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Grant selection and push-port muxing; all zero-latency.
  always_comb begin
    gnt_o       = '0;
    sel_idx     = idx_hold;
    any_gnt     = 1'b0;
    req_ready_o = '0;
    fifo_data_o = '0;
    open        = ~fifo_full_i & ~flush_i;

    if (state == ARB_LOCKED) begin
      // Owner keeps the grant even while its valid is low (bubbles allowed).
      gnt_o[owner] = 1'b1;
      sel_idx      = owner;
      any_gnt      = 1'b1;
    end else if (pick_any) begin
      gnt_o   = pick_gnt;
      sel_idx = pick_idx;
      any_gnt = 1'b1;
    end

    if (any_gnt) begin
      req_ready_o[sel_idx] = open;
      fifo_data_o          = req_data_i[sel_idx];
    end

    xfer       = any_gnt & req_valid_i[sel_idx] & open;
    fifo_wen_o = xfer;
    gnt_idx_o  = sel_idx;
    locked_o   = (state == ARB_LOCKED);
  end

  // Arbitration FSM. Nothing moves without a transfer, so a requester stalled
  // by full keeps both its grant and its priority.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst_i || flush_i) begin
      state <= ARB_IDLE;
      ptr   <= IW'(N - 1);  // requester 0 is highest priority next
      owner <= '0;
      if (rst_i) idx_hold <= '0;
    end else begin
      if (any_gnt) idx_hold <= sel_idx;
      if (xfer) begin
        case (state)
          ARB_IDLE: begin
            ptr <= sel_idx;
            // Single-beat packets never enter LOCKED.
            if (LOCK && !req_last_i[sel_idx]) begin
              state <= ARB_LOCKED;
              owner <= sel_idx;
            end
          end
          ARB_LOCKED: begin
            if (req_last_i[owner]) begin
              state <= ARB_IDLE;
              ptr   <= owner;
            end
          end
          default: state <= ARB_IDLE;
        endcase
      end
    end
  end

`ifdef GNRC_FIFO_ARB_STATS_EN
  logic [N-1:0][STAT_W-1:0] stat_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      stat_q <= '0;
    end else if (xfer && (stat_q[sel_idx] != '1)) begin
      stat_q[sel_idx] <= stat_q[sel_idx] + STAT_W'(1);
    end
  end

  assign stat_cnt_o = stat_q;
`endif

endmodule

// File: tb/tb_gnrc_fifo_wr_arb.sv
// tb_gnrc_fifo_wr_arb
//   Directed bench for gnrc_fifo_wr_arb. Two instances share every input:
//   u0 has LOCK=0 (per-beat re-arbitration), u1 has LOCK=1 (packet lock).
//   Inputs change 1 time unit after the rising edge; outputs are checked
//   1 unit later, well away from the next edge.
module tb_gnrc_fifo_wr_arb;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 flush;
  logic                 full;
  logic [N-1:0]         valid;
  logic [N-1:0]         last;
  logic [N-1:0][DW-1:0] data;

  logic [N-1:0]  ready0, ready1, gnt0, gnt1;
  logic          wen0, wen1, locked0, locked1;
  logic [DW-1:0] fdata0, fdata1;
  logic [IW-1:0] idx0, idx1;
`ifdef GNRC_FIFO_ARB_STATS_EN
  logic [N-1:0][15:0] stat0, stat1;
`endif

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  gnrc_fifo_wr_arb #(.N(N), .DW(DW), .LOCK(1'b0)) u0 (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .req_valid_i (valid),
    .req_data_i  (data),
    .req_last_i  (last),
    .req_ready_o (ready0),
    .fifo_wen_o  (wen0),
    .fifo_data_o (fdata0),
    .fifo_full_i (full),
    .gnt_o       (gnt0),
    .gnt_idx_o   (idx0),
    .locked_o    (locked0)
`ifdef GNRC_FIFO_ARB_STATS_EN
    ,
    .stat_cnt_o  (stat0)
`endif
  );

  gnrc_fifo_wr_arb #(.N(N), .DW(DW), .LOCK(1'b1)) u1 (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .req_valid_i (valid),
    .req_data_i  (data),
    .req_last_i  (last),
    .req_ready_o (ready1),
    .fifo_wen_o  (wen1),
    .fifo_data_o (fdata1),
    .fifo_full_i (full),
    .gnt_o       (gnt1),
    .gnt_idx_o   (idx1),
    .locked_o    (locked1)
`ifdef GNRC_FIFO_ARB_STATS_EN
    ,
    .stat_cnt_o  (stat1)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    flush = 1'b0;
    full  = 1'b0;
    valid = '0;
    last  = '0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    full  = 1'b0;
    valid = '0;
    last  = '0;
    for (int i = 0; i < N; i++) data[i] = 32'hA0 + i;

    // ---------------- reset values ----------------
    do_reset();
    #1;
    check("rst_ready0",  32'(ready0),  32'h0);
    check("rst_wen0",    32'(wen0),    32'h0);
    check("rst_gnt0",    32'(gnt0),    32'h0);
    check("rst_idx0",    32'(idx0),    32'h0);
    check("rst_locked0", 32'(locked0), 32'h0);
    check("rst_ready1",  32'(ready1),  32'h0);
    check("rst_wen1",    32'(wen1),    32'h0);
    check("rst_gnt1",    32'(gnt1),    32'h0);
    check("rst_idx1",    32'(idx1),    32'h0);
    check("rst_locked1", 32'(locked1), 32'h0);

    // ---------------- LOCK=0 round robin: 0,1,2,3,0 ----------------
    valid = 4'hF;
    last  = 4'hF;
    #1;
    for (int c = 0; c < 5; c++) begin
      check("rr_gnt",   32'(gnt0),   32'(1) << (c % 4));
      check("rr_idx",   32'(idx0),   32'(c % 4));
      check("rr_wen",   32'(wen0),   32'h1);
      check("rr_data",  fdata0,      32'hA0 + 32'(c % 4));
      check("rr_ready", 32'(ready0), 32'(1) << (c % 4));
      tick();
    end

    // ---------------- LOCK=1: req1 3-beat packet ----------------
    do_reset();
    valid   = 4'hF;
    last    = 4'b1101;
    data[1] = 32'h11;
    #1;
    // req0 single beat, moves ptr to 0 so req1 wins next
    check("lk_a_gnt",    32'(gnt1),    32'h1);
    check("lk_a_wen",    32'(wen1),    32'h1);
    check("lk_a_locked", 32'(locked1), 32'h0);
    tick();
    check("lk_b_gnt",    32'(gnt1),    32'h2);
    check("lk_b_data",   fdata1,       32'h11);
    check("lk_b_wen",    32'(wen1),    32'h1);
    check("lk_b_locked", 32'(locked1), 32'h0);
    tick();
    data[1] = 32'h12;
    #1;
    check("lk_c_gnt",    32'(gnt1),    32'h2);
    check("lk_c_ready",  32'(ready1),  32'h2);
    check("lk_c_data",   fdata1,       32'h12);
    check("lk_c_locked", 32'(locked1), 32'h1);
    tick();
    data[1] = 32'h13;
    last[1] = 1'b1;
    #1;
    check("lk_d_gnt",    32'(gnt1),    32'h2);
    check("lk_d_data",   fdata1,       32'h13);
    check("lk_d_wen",    32'(wen1),    32'h1);
    check("lk_d_locked", 32'(locked1), 32'h1);
    tick();
    check("lk_e_gnt",    32'(gnt1),    32'h4);
    check("lk_e_idx",    32'(idx1),    32'h2);
    check("lk_e_locked", 32'(locked1), 32'h0);

    // ---------------- full for 5 cycles with req2 granted ----------------
    full = 1'b1;
    #1;
    for (int c = 0; c < 5; c++) begin
      check("full_wen",   32'(wen1),   32'h0);
      check("full_ready", 32'(ready1), 32'h0);
      check("full_idx",   32'(idx1),   32'h2);
      tick();
    end
    full = 1'b0;
    #1;
    check("unfull_wen",   32'(wen1),   32'h1);
    check("unfull_ready", 32'(ready1), 32'h4);
    check("unfull_data",  fdata1,      32'hA2);
    tick();
    valid = '0;
    #1;
    check("idle_gnt",  32'(gnt1), 32'h0);
    check("idle_hold", 32'(idx1), 32'h2);
    check("idle_wen",  32'(wen1), 32'h0);

    // ---------------- flush mid-packet, owner 3 ----------------
    do_reset();
    valid   = 4'b1000;
    last    = 4'b0000;
    data[3] = 32'hD3;
    #1;
    check("fl_b1_gnt", 32'(gnt1), 32'h8);
    check("fl_b1_wen", 32'(wen1), 32'h1);
    tick();
    valid   = 4'b1011;
    last[0] = 1'b1;
    flush   = 1'b1;
    #1;
    check("fl_b2_locked", 32'(locked1), 32'h1);
    check("fl_b2_wen",    32'(wen1),    32'h0);
    check("fl_b2_ready",  32'(ready1),  32'h0);
    tick();
    flush = 1'b0;
    #1;
    check("fl_post_locked", 32'(locked1), 32'h0);
    check("fl_post_gnt",    32'(gnt1),    32'h1);
    check("fl_post_wen",    32'(wen1),    32'h1);

    // ---------------- owner bubble while locked ----------------
    do_reset();
    valid = 4'b1000;
    last  = 4'b0000;
    #1;
    check("bb_b1_gnt", 32'(gnt1), 32'h8);
    check("bb_b1_wen", 32'(wen1), 32'h1);
    tick();
    valid = 4'b0001;
    #1;
    for (int c = 0; c < 2; c++) begin
      check("bb_gnt",    32'(gnt1),    32'h8);
      check("bb_wen",    32'(wen1),    32'h0);
      check("bb_ready",  32'(ready1),  32'h8);
      check("bb_locked", 32'(locked1), 32'h1);
      tick();
    end
    valid   = 4'b1001;
    last    = 4'b1000;
    data[3] = 32'hD4;
    #1;
    check("bb_res_gnt",  32'(gnt1), 32'h8);
    check("bb_res_wen",  32'(wen1), 32'h1);
    check("bb_res_data", fdata1,    32'hD4);
    tick();
    check("bb_end_locked", 32'(locked1), 32'h0);
    check("bb_end_gnt",    32'(gnt1),    32'h1);

`ifdef GNRC_FIFO_ARB_STATS_EN
    // ---------------- saturating beat counter ----------------
    do_reset();
    valid = 4'b0001;
    last  = 4'b0001;
    #1;
    repeat (5) tick();
    check("st_5", 32'(stat0[0]), 32'h5);
    repeat (69995) tick();
    check("st_sat0", 32'(stat0[0]), 32'hFFFF);
    check("st_sat1", 32'(stat0[1]), 32'h0);
    check("st_sat2", 32'(stat0[2]), 32'h0);
    check("st_sat3", 32'(stat0[3]), 32'h0);
    valid = '0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    check("st_flush", 32'(stat0[0]), 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
